// File: rtl/branch_predictor.sv
// Direct-mapped branch target buffer with zero-latency lookup and misprediction flush/counters.
// Define BRANCH_PREDICTOR_BHT_EN to add a 2-bit saturating direction counter per entry.
module branch_predictor #(
    parameter int ENTRY_BITS = 6
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] PC_IF,
    output logic        pred_taken,
    output logic [31:0] pred_target,
    input  logic        upd_valid,
    input  logic [31:0] upd_pc,
    input  logic        upd_taken,
    input  logic [31:0] upd_target,
    input  logic        upd_pred_taken,
    input  logic [31:0] upd_pred_target,
    output logic        mispredict,
    output logic [31:0] br_cnt,
    output logic [31:0] mispred_cnt
);
    localparam int DEPTH = 1 << ENTRY_BITS;
    localparam int TAG_W = 30 - ENTRY_BITS;

    logic [DEPTH-1:0]      valid_q;
    logic [TAG_W-1:0]      tag_q    [DEPTH];
    logic [31:0]           target_q [DEPTH];

    logic [ENTRY_BITS-1:0] if_idx;
    logic [TAG_W-1:0]      if_tag;
    logic                  if_hit;
    logic                  taken_bit;

    logic [ENTRY_BITS-1:0] upd_idx;
    logic [TAG_W-1:0]      upd_tag;
    logic                  upd_hit;

    // Word-aligned PCs: the low two bits never reach the table.
    logic                  unused_upd_pc;
    assign unused_upd_pc = &{1'b0, upd_pc[1:0]};

    assign if_idx  = PC_IF[ENTRY_BITS+1:2];
    assign if_tag  = PC_IF[31:ENTRY_BITS+2];
    assign if_hit  = valid_q[if_idx] && (tag_q[if_idx] == if_tag);

    assign upd_idx = upd_pc[ENTRY_BITS+1:2];
    assign upd_tag = upd_pc[31:ENTRY_BITS+2];
    assign upd_hit = valid_q[upd_idx] && (tag_q[upd_idx] == upd_tag);

`ifdef BRANCH_PREDICTOR_BHT_EN
    logic [1:0] cnt_q [DEPTH];
    logic [1:0] upd_cnt;
    logic [1:0] cnt_inc;
    logic [1:0] cnt_dec;

    assign taken_bit = cnt_q[if_idx][1];
    assign upd_cnt   = cnt_q[upd_idx];
    assign cnt_inc   = (upd_cnt == 2'b11) ? 2'b11 : upd_cnt + 2'd1;
    assign cnt_dec   = (upd_cnt == 2'b00) ? 2'b00 : upd_cnt - 2'd1;
`else
    assign taken_bit = 1'b1;
`endif

    assign pred_taken  = if_hit && taken_bit;
    assign pred_target = pred_taken ? target_q[if_idx] : PC_IF + 32'd4;

    assign mispredict = upd_valid &&
                        ((upd_pred_taken != upd_taken) ||
                         (upd_taken && (upd_pred_target != upd_target)));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            valid_q <= '0;
`ifdef BRANCH_PREDICTOR_BHT_EN
            for (int i = 0; i < DEPTH; i++) cnt_q[i] <= 2'b00;
`endif
        end else if (upd_valid) begin
            if (upd_taken) begin
                valid_q[upd_idx] <= 1'b1;
`ifdef BRANCH_PREDICTOR_BHT_EN
                cnt_q[upd_idx]   <= upd_hit ? cnt_inc : 2'b10;
`endif
            end else if (upd_hit) begin
`ifdef BRANCH_PREDICTOR_BHT_EN
                cnt_q[upd_idx]   <= cnt_dec;
`else
                valid_q[upd_idx] <= 1'b0;
`endif
            end
        end
    end

    // Tag/target are qualified by valid, so they need no reset.
    always_ff @(posedge clk) begin
        if (upd_valid && upd_taken) begin
            tag_q[upd_idx]    <= upd_tag;
            target_q[upd_idx] <= upd_target;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            br_cnt      <= '0;
            mispred_cnt <= '0;
        end else begin
            if (upd_valid)  br_cnt      <= br_cnt + 32'd1;
            if (mispredict) mispred_cnt <= mispred_cnt + 32'd1;
        end
    end
endmodule

// File: tb/tb_branch_predictor.sv
// Self-checking bench for branch_predictor: directed scenarios plus randomized traffic
// against a table model built from the prediction/update rules.
module tb_branch_predictor;
    localparam int EB    = 6;
    localparam int DEPTH = 1 << EB;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [31:0] PC_IF = 32'h0;
    logic        pred_taken;
    logic [31:0] pred_target;
    logic        upd_valid = 1'b0;
    logic [31:0] upd_pc = 32'h0;
    logic        upd_taken = 1'b0;
    logic [31:0] upd_target = 32'h0;
    logic        upd_pred_taken = 1'b0;
    logic [31:0] upd_pred_target = 32'h0;
    logic        mispredict;
    logic [31:0] br_cnt;
    logic [31:0] mispred_cnt;

    int vec  = 0;
    int errs = 0;

    branch_predictor #(.ENTRY_BITS(EB)) dut (
        .clk(clk), .rst(rst), .PC_IF(PC_IF),
        .pred_taken(pred_taken), .pred_target(pred_target),
        .upd_valid(upd_valid), .upd_pc(upd_pc), .upd_taken(upd_taken),
        .upd_target(upd_target), .upd_pred_taken(upd_pred_taken),
        .upd_pred_target(upd_pred_target), .mispredict(mispredict),
        .br_cnt(br_cnt), .mispred_cnt(mispred_cnt)
    );

    always #5 clk = ~clk;

    // Reference table, indexed and tagged with plain arithmetic on the PC.
    bit          m_valid  [DEPTH];
    int unsigned m_tag    [DEPTH];
    logic [31:0] m_target [DEPTH];
    int          m_cnt    [DEPTH];
    logic [31:0] m_br;
    logic [31:0] m_mp;

`ifdef BRANCH_PREDICTOR_BHT_EN
    localparam bit BHT = 1'b1;
`else
    localparam bit BHT = 1'b0;
`endif

    function automatic int m_index(input logic [31:0] pc);
        return int'((pc / 4) % DEPTH);
    endfunction

    function automatic bit m_hit(input logic [31:0] pc);
        int i = m_index(pc);
        return m_valid[i] && (m_tag[i] == int'(pc / (4 * DEPTH)));
    endfunction

    function automatic void m_predict(input logic [31:0] pc, output bit tk, output logic [31:0] tg);
        int i = m_index(pc);
        tk = m_hit(pc) && (!BHT || m_cnt[i] >= 2);
        tg = tk ? m_target[i] : pc + 32'd4;
    endfunction

    function automatic bit m_mispredict();
        return upd_valid && ((upd_pred_taken != upd_taken) ||
                             (upd_taken && (upd_pred_target != upd_target)));
    endfunction

    task automatic model_reset();
        for (int i = 0; i < DEPTH; i++) begin
            m_valid[i] = 1'b0;
            m_cnt[i]   = 0;
        end
        m_br = 32'd0;
        m_mp = 32'd0;
    endtask

    task automatic model_update();
        int i;
        bit h;
        if (!upd_valid) return;
        i = m_index(upd_pc);
        h = m_hit(upd_pc);
        m_br = m_br + 32'd1;
        if (m_mispredict()) m_mp = m_mp + 32'd1;
        if (upd_taken) begin
            m_cnt[i]    = h ? ((m_cnt[i] < 3) ? m_cnt[i] + 1 : 3) : 2;
            m_valid[i]  = 1'b1;
            m_tag[i]    = int'(upd_pc / (4 * DEPTH));
            m_target[i] = upd_target;
        end else if (h) begin
            if (BHT) m_cnt[i] = (m_cnt[i] > 0) ? m_cnt[i] - 1 : 0;
            else     m_valid[i] = 1'b0;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_update();
        #1;
    endtask

    task automatic do_reset();
        upd_valid = 1'b0;
        rst = 1'b0;
        model_reset();
        @(posedge clk);
        #1;
        rst = 1'b1;
    endtask

    task automatic drive_upd(input logic [31:0] pc, input logic tk, input logic [31:0] tg,
                             input logic ptk, input logic [31:0] ptg);
        upd_valid = 1'b1; upd_pc = pc; upd_taken = tk; upd_target = tg;
        upd_pred_taken = ptk; upd_pred_target = ptg;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        PC_IF = 32'h100;
        model_reset();
        #2;
        vec++; if (pred_taken !== 1'b0) begin errs++; $display("FAIL reset_pred_taken got %0b exp 0", pred_taken); end
        vec++; if (pred_target !== 32'h104) begin errs++; $display("FAIL reset_pred_target got %h exp 00000104", pred_target); end
        vec++; if (br_cnt !== 32'd0) begin errs++; $display("FAIL reset_br_cnt got %0d exp 0", br_cnt); end
        vec++; if (mispred_cnt !== 32'd0) begin errs++; $display("FAIL reset_mispred_cnt got %0d exp 0", mispred_cnt); end
        @(posedge clk);
        #1;
        rst = 1'b1;
    endtask

    task automatic test_allocate_and_train();
        logic exp_tk;
        do_reset();
        PC_IF = 32'h100;
        drive_upd(32'h100, 1'b1, 32'h80, 1'b0, 32'h104);
        tick();
        upd_valid = 1'b0;
        #1;
        vec++; if (pred_taken !== 1'b1) begin errs++; $display("FAIL alloc_pred_taken got %0b exp 1", pred_taken); end
        vec++; if (pred_target !== 32'h80) begin errs++; $display("FAIL alloc_pred_target got %h exp 00000080", pred_target); end
        drive_upd(32'h100, 1'b0, 32'h80, 1'b1, 32'h80);
        tick();
        upd_valid = 1'b0;
        #1;
        vec++; if (pred_taken !== 1'b0) begin errs++; $display("FAIL nt1_pred_taken got %0b exp 0", pred_taken); end
        vec++; if (pred_target !== 32'h104) begin errs++; $display("FAIL nt1_pred_target got %h exp 00000104", pred_target); end
        drive_upd(32'h100, 1'b0, 32'h80, 1'b0, 32'h104);
        tick();
        drive_upd(32'h100, 1'b1, 32'h80, 1'b0, 32'h104);
        tick();
        upd_valid = 1'b0;
        #1;
        // BHT: 01 -> 00 -> 01 (still not taken). BTB-only: second not-taken missed, taken re-allocates.
        exp_tk = BHT ? 1'b0 : 1'b1;
        vec++; if (pred_taken !== exp_tk) begin errs++; $display("FAIL retrain_pred_taken got %0b exp %0b", pred_taken, exp_tk); end
    endtask

    task automatic test_saturation_and_replace();
        do_reset();
        PC_IF = 32'h40;
        for (int k = 0; k < 3; k++) begin
            drive_upd(32'h40, 1'b1, 32'h900, 1'b0, 32'h44);
            tick();
        end
        drive_upd(32'h40, 1'b0, 32'h900, 1'b1, 32'h900);
        tick();
        upd_valid = 1'b0;
        #1;
        vec++; if (pred_taken !== BHT) begin errs++; $display("FAIL sat_nt1_pred_taken got %0b exp %0b", pred_taken, BHT); end
        drive_upd(32'h40, 1'b0, 32'h900, 1'b1, 32'h900);
        tick();
        upd_valid = 1'b0;
        #1;
        vec++; if (pred_taken !== 1'b0) begin errs++; $display("FAIL sat_nt2_pred_taken got %0b exp 0", pred_taken); end
        drive_upd(32'h140, 1'b1, 32'hA00, 1'b0, 32'h144);
        tick();
        upd_valid = 1'b0;
        PC_IF = 32'h140;
        #1;
        vec++; if (pred_target !== 32'hA00) begin errs++; $display("FAIL replace_pred_target got %h exp 00000a00", pred_target); end
        PC_IF = 32'h40;
        #1;
        vec++; if (pred_taken !== 1'b0) begin errs++; $display("FAIL replaced_old_pred_taken got %0b exp 0", pred_taken); end
    endtask

    task automatic test_alias();
        do_reset();
        drive_upd(32'h100, 1'b1, 32'h80, 1'b0, 32'h104);
        tick();
        upd_valid = 1'b0;
        PC_IF = 32'h200;
        #1;
        vec++; if (pred_taken !== 1'b0) begin errs++; $display("FAIL alias_pred_taken got %0b exp 0", pred_taken); end
        vec++; if (pred_target !== 32'h204) begin errs++; $display("FAIL alias_pred_target got %h exp 00000204", pred_target); end
        PC_IF = 32'h100;
        #1;
        vec++; if (pred_taken !== 1'b1) begin errs++; $display("FAIL alias_owner_pred_taken got %0b exp 1", pred_taken); end
    endtask

    task automatic test_same_cycle();
        do_reset();
        PC_IF = 32'h100;
        drive_upd(32'h100, 1'b1, 32'h80, 1'b0, 32'h104);
        #1;
        vec++; if (pred_taken !== 1'b0) begin errs++; $display("FAIL same_cycle_old_pred_taken got %0b exp 0", pred_taken); end
        tick();
        upd_valid = 1'b0;
        #1;
        vec++; if (pred_taken !== 1'b1) begin errs++; $display("FAIL same_cycle_next_pred_taken got %0b exp 1", pred_taken); end
    endtask

    task automatic test_mispredict_counters();
        do_reset();
        drive_upd(32'h100, 1'b1, 32'h80, 1'b0, 32'h104);
        #1;
        vec++; if (mispredict !== 1'b1) begin errs++; $display("FAIL mp_dir_mispredict got %0b exp 1", mispredict); end
        tick();
        drive_upd(32'h100, 1'b1, 32'h80, 1'b1, 32'h88);
        #1;
        vec++; if (mispredict !== 1'b1) begin errs++; $display("FAIL mp_target_mispredict got %0b exp 1", mispredict); end
        drive_upd(32'h100, 1'b0, 32'h80, 1'b0, 32'h88);
        #1;
        vec++; if (mispredict !== 1'b0) begin errs++; $display("FAIL mp_nt_correct_mispredict got %0b exp 0", mispredict); end
        upd_valid = 1'b0;
        #1;
        vec++; if (br_cnt !== 32'd1) begin errs++; $display("FAIL mp_br_cnt got %0d exp 1", br_cnt); end
        vec++; if (mispred_cnt !== 32'd1) begin errs++; $display("FAIL mp_mispred_cnt got %0d exp 1", mispred_cnt); end
        #2;
        rst = 1'b0;
        model_reset();
        #1;
        vec++; if (br_cnt !== 32'd0) begin errs++; $display("FAIL async_rst_br_cnt got %0d exp 0", br_cnt); end
        vec++; if (mispred_cnt !== 32'd0) begin errs++; $display("FAIL async_rst_mispred_cnt got %0d exp 0", mispred_cnt); end
        PC_IF = 32'h100;
        #1;
        vec++; if (pred_taken !== 1'b0) begin errs++; $display("FAIL async_rst_pred_taken got %0b exp 0", pred_taken); end
        rst = 1'b1;
        tick();
    endtask

    task automatic test_random();
        logic [31:0] pool [8];
        bit          etk;
        logic [31:0] etg;
        bit          emp;
        pool = '{32'h100, 32'h200, 32'h104, 32'h1100, 32'h40, 32'h140, 32'hFFFF_FFFC, 32'h3F8};
        do_reset();
        for (int n = 0; n < 300; n++) begin
            PC_IF     = pool[$urandom_range(0, 7)];
            upd_valid = ($urandom_range(0, 3) != 0);
            upd_pc    = pool[$urandom_range(0, 7)];
            upd_taken = $urandom_range(0, 1);
            upd_target = {$urandom_range(0, 255), 2'b00} & 32'h3FC;
            if ($urandom_range(0, 1) != 0) begin
                m_predict(upd_pc, etk, etg);
                upd_pred_taken  = etk;
                upd_pred_target = etg;
            end else begin
                upd_pred_taken  = $urandom_range(0, 1);
                upd_pred_target = upd_target ^ (($urandom_range(0, 1) != 0) ? 32'h10 : 32'h0);
            end
            @(negedge clk);
            m_predict(PC_IF, etk, etg);
            emp = m_mispredict();
            vec++; if (pred_taken !== etk) begin errs++; $display("FAIL rnd%0d_pred_taken got %0b exp %0b", n, pred_taken, etk); end
            vec++; if (pred_target !== etg) begin errs++; $display("FAIL rnd%0d_pred_target got %h exp %h", n, pred_target, etg); end
            vec++; if (mispredict !== emp) begin errs++; $display("FAIL rnd%0d_mispredict got %0b exp %0b", n, mispredict, emp); end
            vec++; if (br_cnt !== m_br) begin errs++; $display("FAIL rnd%0d_br_cnt got %0d exp %0d", n, br_cnt, m_br); end
            vec++; if (mispred_cnt !== m_mp) begin errs++; $display("FAIL rnd%0d_mispred_cnt got %0d exp %0d", n, mispred_cnt, m_mp); end
            tick();
        end
        upd_valid = 1'b0;
    endtask

    initial begin
        test_reset();
        test_allocate_and_train();
        test_saturation_and_replace();
        test_alias();
        test_same_cycle();
        test_mispredict_counters();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
        $finish;
    end
endmodule
